// File: rtl/overvoltage_detector_if.sv
// ============================================================================
// overvoltage_detector_if : digital control/status bundle of the AVDD monitor
// Rev 1.0
// ============================================================================
`default_nettype none

interface overvoltage_detector_if;
    logic       avss;
    logic       dvdd;
    logic       dvss;
    logic [3:0] otrip;
    logic       ena;
    logic       isrc_sel;
    logic       ovout;

    modport master (
        output avss, dvdd, dvss, otrip, ena, isrc_sel,
        input  ovout
    );

    modport slave (
        input  avss, dvdd, dvss, otrip, ena, isrc_sel,
        output ovout
    );
endinterface

`default_nettype wire

// File: rtl/overvoltage_detector.sv
// ============================================================================
// overvoltage_detector : AVDD overvoltage monitor, divider + hysteretic
//                        comparator + clocked debounce of the flag
// Rev 1.0
// ============================================================================
`default_nettype none

module overvoltage_detector #(
    parameter int  DEBOUNCE   = 4,
    parameter real VTRIP_BASE = 2.5,
    parameter real VTRIP_STEP = 0.2,
    parameter real HYST       = 0.02,
    parameter real IBIAS_INT  = 200e-9
) (
    input  logic clk,
    input  logic rst_n,
    input  real  avdd,
    input  real  vbg_1v2,
    input  real  ibg_200n,
    output real  itest,
    output real  vin,
    overvoltage_detector_if.slave bus
);

    localparam logic [8:0] DEB_LIMIT = 9'(DEBOUNCE);

    logic       pg;
    logic       active;
    logic       cmp;
    logic       flag;
    logic [7:0] cnt;
    logic [8:0] cnt_next;
    real        vtrip;

    assign pg       = bus.dvdd & ~bus.dvss & ~bus.avss;
    assign active   = pg & bus.ena;
    assign cnt_next = {1'b0, cnt} + 9'd1;
    assign bus.ovout = flag;

    always_comb begin
        vtrip = VTRIP_BASE + VTRIP_STEP * real'(bus.otrip);
        vin   = 0.0;
        itest = 0.0;
        if (active) begin
            vin   = avdd * 1.2 / vtrip;
            itest = bus.isrc_sel ? ibg_200n : IBIAS_INT;
        end
    end

    // Threshold moves down by HYST once the flag is set, so a trip holds
    // until vin falls clearly below the reference.
    always_comb begin
        cmp = 1'b0;
        if (active) begin
            if (flag)
                cmp = (vin > (vbg_1v2 - HYST / 2.0));
            else
                cmp = (vin > (vbg_1v2 + HYST / 2.0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag <= 1'b0;
            cnt  <= 8'd0;
        end else if (!active) begin
            flag <= 1'b0;
            cnt  <= 8'd0;
        end else if (cmp == flag) begin
            cnt  <= 8'd0;
        end else if (cnt_next == DEB_LIMIT) begin
            flag <= cmp;
            cnt  <= 8'd0;
        end else begin
            cnt  <= cnt_next[7:0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_overvoltage_detector.sv
// ============================================================================
// tb_overvoltage_detector : scoreboard bench for the AVDD overvoltage monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_overvoltage_detector;

    logic clk;
    logic rst_n;
    real  avdd;
    real  vbg_1v2;
    real  ibg_200n;
    real  itest;
    real  vin;

    overvoltage_detector_if bus ();

    overvoltage_detector dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .avdd     (avdd),
        .vbg_1v2  (vbg_1v2),
        .ibg_200n (ibg_200n),
        .itest    (itest),
        .vin      (vin),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks_total  = 0;
    int   checks_passed = 0;
    logic exp_q[$];

    task automatic check(input string tag, input real obs, input real exp);
        real diff;
        real tol;
        diff = obs - exp;
        if (diff < 0.0) diff = -diff;
        tol = (exp < 0.0 ? -exp : exp) * 1.0e-4 + 1.0e-15;
        checks_total++;
        if (diff <= tol)
            checks_passed++;
        else
            $display("FAIL %s: got %g, expected %g (t=%0t)", tag, obs, exp, $time);
    endtask

    // Expected flag for the coming edge is queued, then compared just after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            check("ovout", real'(bus.ovout), real'(e));
        end
    end

    task automatic tick(input logic exp);
        exp_q.push_back(exp);
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n, input logic exp);
        for (int i = 0; i < n; i++) tick(exp);
    endtask

    initial begin
        rst_n        = 1'b0;
        avdd         = 0.0;
        vbg_1v2      = 1.2;
        ibg_200n     = 200e-9;
        bus.avss     = 1'b0;
        bus.dvdd     = 1'b1;
        bus.dvss     = 1'b0;
        bus.otrip    = 4'd15;
        bus.ena      = 1'b0;
        bus.isrc_sel = 1'b0;
        #1;
        check("reset_ovout", real'(bus.ovout), 0.0);
        ticks(2, 1'b0);
        rst_n = 1'b1;

        // Low AVDD, highest trip point
        avdd    = 2.0;
        bus.ena = 1'b1;
        #1;
        check("vin_2v0", vin, 2.0 * 1.2 / 5.5);
        check("itest_int", itest, 200e-9);
        ticks(3, 1'b0);

        avdd = 5.4;
        #1;
        check("vin_5v4", vin, 1.1781818);
        ticks(6, 1'b0);

        // Trip: exactly on the 4th edge
        avdd = 5.6;
        #1;
        check("vin_5v6", vin, 1.2218182);
        ticks(3, 1'b0);
        ticks(2, 1'b1);

        avdd = 3.3;
        ticks(3, 1'b1);
        ticks(2, 1'b0);

        // Lowest trip point
        bus.otrip = 4'd0;
        avdd      = 2.6;
        ticks(3, 1'b0);
        ticks(2, 1'b1);
        avdd = 2.4;
        ticks(3, 1'b1);
        ticks(2, 1'b0);

        // Enable pulse while tripped
        avdd = 2.6;
        ticks(3, 1'b0);
        tick(1'b1);
        bus.ena = 1'b0;
        #1;
        check("vin_dis", vin, 0.0);
        check("itest_dis", itest, 0.0);
        tick(1'b0);
        bus.ena = 1'b1;
        ticks(3, 1'b0);
        ticks(2, 1'b1);

        // Glitches of 3 samples never release the flag
        for (int g = 0; g < 2; g++) begin
            avdd = 2.4;
            ticks(3, 1'b1);
            avdd = 2.6;
            tick(1'b1);
        end

        // Asynchronous reset clears the flag between edges
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", real'(bus.ovout), 0.0);
        ticks(2, 1'b0);
        rst_n = 1'b1;
        ticks(3, 1'b0);
        tick(1'b1);

        // Release, then re-trip interrupted by reset: count restarts
        avdd = 2.4;
        ticks(3, 1'b1);
        tick(1'b0);
        avdd = 2.6;
        ticks(2, 1'b0);
        rst_n = 1'b0;
        tick(1'b0);
        rst_n = 1'b1;
        ticks(3, 1'b0);
        ticks(2, 1'b1);

        // Supply loss clears in one edge
        bus.dvdd = 1'b0;
        #1;
        check("vin_nopg", vin, 0.0);
        tick(1'b0);
        bus.dvdd = 1'b1;
        bus.avss = 1'b1;
        ticks(5, 1'b0);
        bus.avss = 1'b0;
        ticks(3, 1'b0);
        tick(1'b1);

        // External bias source
        bus.isrc_sel = 1'b1;
        ibg_200n     = 150e-9;
        #1;
        check("itest_ext", itest, 150e-9);
        tick(1'b1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
